// File: rtl/decoder_3to8_hs.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides and a 2-entry skid buffer.
// Optional even-parity input check enabled by defining DEC_PARITY_EN.
module decoder_3to8_hs #(
    parameter int IN_W  = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 En,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_code,
`ifdef DEC_PARITY_EN
    input  logic                 in_par,
    output logic                 par_err,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2**IN_W-1:0]   out_onehot,
    output logic [IN_W-1:0]      out_code,
    output logic [CNT_W-1:0]     dec_count
);

    localparam int OUT_W = 2**IN_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   out_onehot_q, out_onehot_d;
    logic [IN_W-1:0]    out_code_q, out_code_d;
    logic [OUT_W-1:0]   skid_onehot_q, skid_onehot_d;
    logic [IN_W-1:0]    skid_code_q, skid_code_d;
    logic [CNT_W-1:0]   dec_count_q, dec_count_d;

    logic               push;
    logic               pop;
    logic               accept;
    logic [OUT_W-1:0]   new_onehot;

    assign in_ready   = En & (state_q != ST_FULL);
    assign out_valid  = (state_q != ST_EMPTY);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign new_onehot = OUT_W'(1) << in_code;

`ifdef DEC_PARITY_EN
    logic par_err_q, par_err_d;

    // A bad entry still completes the input handshake; it is just not stored.
    assign accept    = push & ~(^{in_code, in_par});
    assign par_err_d = push & (^{in_code, in_par});
    assign par_err   = par_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_err_q <= 1'b0;
        else     par_err_q <= par_err_d;
    end
`else
    assign accept = push;
`endif

    always_comb begin
        state_d       = state_q;
        out_onehot_d  = out_onehot_q;
        out_code_d    = out_code_q;
        skid_onehot_d = skid_onehot_q;
        skid_code_d   = skid_code_q;
        dec_count_d   = dec_count_q + (pop ? CNT_W'(1) : CNT_W'(0));

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d      = ST_ONE;
                    out_onehot_d = new_onehot;
                    out_code_d   = in_code;
                end
            end
            ST_ONE: begin
                if (accept && !pop) begin
                    state_d       = ST_FULL;
                    skid_onehot_d = new_onehot;
                    skid_code_d   = in_code;
                end else if (accept && pop) begin
                    out_onehot_d = new_onehot;
                    out_code_d   = in_code;
                end else if (pop) begin
                    state_d      = ST_EMPTY;
                    out_onehot_d = '0;
                    out_code_d   = '0;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d       = ST_ONE;
                    out_onehot_d  = skid_onehot_q;
                    out_code_d    = skid_code_q;
                    skid_onehot_d = '0;
                    skid_code_d   = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            out_onehot_q  <= '0;
            out_code_q    <= '0;
            skid_onehot_q <= '0;
            skid_code_q   <= '0;
            dec_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            out_onehot_q  <= out_onehot_d;
            out_code_q    <= out_code_d;
            skid_onehot_q <= skid_onehot_d;
            skid_code_q   <= skid_code_d;
            dec_count_q   <= dec_count_d;
        end
    end

    // Gate with out_valid so no stale one-hot is ever visible.
    assign out_onehot = out_valid ? out_onehot_q : '0;
    assign out_code   = out_valid ? out_code_q : '0;
    assign dec_count  = dec_count_q;

endmodule

// File: tb/tb_decoder_3to8_hs.sv
// Directed self-checking bench for decoder_3to8_hs.
module tb_decoder_3to8_hs;

    logic       clk;
    logic       rst;
    logic       En;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_onehot;
    logic [2:0] out_code;
    logic [7:0] dec_count;
    logic       in_par;
`ifdef DEC_PARITY_EN
    logic       par_err;
`endif

    int total;
    int bad;

    logic [7:0] exp_oh [8];

    decoder_3to8_hs dut (
        .clk        (clk),
        .rst        (rst),
        .En         (En),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
`ifdef DEC_PARITY_EN
        .in_par     (in_par),
        .par_err    (par_err),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_code   (out_code),
        .dec_count  (dec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [2:0] c);
        in_valid = v;
        in_code  = c;
        in_par   = ^c;
    endtask

    task automatic test_reset();
        rst = 1'b1; En = 1'b0; out_ready = 1'b0;
        drive_in(1'b0, 3'd0);
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_onehot !== 8'h00) begin bad++; $display("FAIL rst_onehot got=%h exp=00", out_onehot); end
        total++; if (dec_count !== 8'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", dec_count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        rst = 1'b0;
        tick();
        En = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_in(1'b1, 3'(i));
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (out_onehot !== exp_oh[i]) begin bad++; $display("FAIL stream_onehot[%0d] got=%h exp=%h", i, out_onehot, exp_oh[i]); end
            total++; if (out_code !== 3'(i)) begin bad++; $display("FAIL stream_code[%0d] got=%0d exp=%0d", i, out_code, i); end
        end
        drive_in(1'b0, 3'd0);
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
        total++; if (dec_count !== 8'd8) begin bad++; $display("FAIL stream_count got=%0d exp=8", dec_count); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive_in(1'b1, 3'd3);
        tick();
        total++; if (out_onehot !== 8'h08) begin bad++; $display("FAIL bp_first got=%h exp=08", out_onehot); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
        drive_in(1'b1, 3'd5);
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        total++; if (out_onehot !== 8'h08) begin bad++; $display("FAIL bp_hold1 got=%h exp=08", out_onehot); end
        drive_in(1'b0, 3'd0);
        tick();
        total++; if (out_onehot !== 8'h08) begin bad++; $display("FAIL bp_hold2 got=%h exp=08", out_onehot); end
        total++; if (out_code !== 3'd3) begin bad++; $display("FAIL bp_hold_code got=%0d exp=3", out_code); end
        out_ready = 1'b1;
        tick();
        total++; if (out_onehot !== 8'h20) begin bad++; $display("FAIL bp_second got=%h exp=20", out_onehot); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
        total++; if (dec_count !== 8'd10) begin bad++; $display("FAIL bp_count got=%0d exp=10", dec_count); end
    endtask

    task automatic test_en_low();
        out_ready = 1'b0;
        drive_in(1'b1, 3'd1);
        tick();
        drive_in(1'b1, 3'd2);
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL en_full_ready got=%b exp=0", in_ready); end
        En = 1'b0;
        drive_in(1'b1, 3'd6);
        out_ready = 1'b1;
        tick();
        total++; if (out_onehot !== 8'h04) begin bad++; $display("FAIL en_drain1 got=%h exp=04", out_onehot); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL en_ready_after got=%b exp=0", in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL en_drain2 got=%b exp=0", out_valid); end
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL en_no_accept got=%b exp=0", out_valid); end
        total++; if (out_onehot !== 8'h00) begin bad++; $display("FAIL en_onehot_zero got=%h exp=00", out_onehot); end
        total++; if (dec_count !== 8'd12) begin bad++; $display("FAIL en_count got=%0d exp=12", dec_count); end
        drive_in(1'b0, 3'd0);
        En = 1'b1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive_in(1'b1, 3'd4);
        tick();
        drive_in(1'b1, 3'd7);
        tick();
        drive_in(1'b0, 3'd0);
        total++; if (out_onehot !== 8'h10) begin bad++; $display("FAIL rm_before got=%h exp=10", out_onehot); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
        total++; if (out_onehot !== 8'h00) begin bad++; $display("FAIL rm_onehot got=%h exp=00", out_onehot); end
        total++; if (dec_count !== 8'd0) begin bad++; $display("FAIL rm_count got=%0d exp=0", dec_count); end
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_after_valid got=%b exp=0", out_valid); end
        total++; if (dec_count !== 8'd0) begin bad++; $display("FAIL rm_after_count got=%0d exp=0", dec_count); end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive_in(1'b1, 3'(i % 8));
            tick();
            e = 8'h01 << (i % 8);
            total++; if (out_onehot !== e) begin bad++; $display("FAIL wrap_onehot[%0d] got=%h exp=%h", i, out_onehot, e); end
        end
        drive_in(1'b0, 3'd0);
        total++; if (dec_count !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", dec_count); end
        tick();
        total++; if (dec_count !== 8'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", dec_count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b exp=0", out_valid); end
    endtask

`ifdef DEC_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd3; in_par = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL par_drop got=%b exp=0", out_valid); end
        total++; if (par_err !== 1'b1) begin bad++; $display("FAIL par_err_hi got=%b exp=1", par_err); end
        tick();
        total++; if (par_err !== 1'b0) begin bad++; $display("FAIL par_err_lo got=%b exp=0", par_err); end
        in_valid = 1'b1; in_code = 3'd3; in_par = 1'b0;
        tick();
        in_valid = 1'b0;
        total++; if (out_onehot !== 8'h08) begin bad++; $display("FAIL par_good got=%h exp=08", out_onehot); end
        total++; if (par_err !== 1'b0) begin bad++; $display("FAIL par_good_err got=%b exp=0", par_err); end
        out_ready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        exp_oh = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        test_reset();
        test_stream();
        test_back_pressure();
        test_en_low();
        test_reset_mid();
        test_wrap();
`ifdef DEC_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
